// File: rtl/ov7670_source_emulator.sv
// OV7670 camera output emulator: VSYNC/HREF/D timing with an 8-bar RGB565 test pattern.
// Optional macro OV_SRC_FRAME_TAG_EN stamps FRAME_CNT into the first pixel of every frame.
module ov7670_source_emulator #(
  parameter int H_ACTIVE    = 160,
  parameter int V_ACTIVE    = 120,
  parameter int H_BLANK     = 16,
  parameter int VSYNC_LINES = 3,
  parameter int V_BACK      = 10,
  parameter int V_FRONT     = 2
) (
  input  logic       PCLK,
  input  logic       RSTN,
  input  logic       ENABLE,
  output logic       VSYNC,
  output logic       HREF,
  output logic [7:0] D,
  output logic       FRAME_DONE,
  output logic [7:0] FRAME_CNT
);

  localparam int L     = 2 * H_ACTIVE + H_BLANK;
  localparam int HW    = $clog2(L);
  localparam int VW    = $clog2(V_ACTIVE + VSYNC_LINES + V_BACK + V_FRONT + 1);
  localparam int BAR_W = H_ACTIVE / 8;
  localparam int PW    = $clog2(BAR_W + 1);

  localparam logic [HW-1:0] H_LAST    = HW'(L - 1);
  localparam logic [HW-1:0] H_ACT_END = HW'(2 * H_ACTIVE);
  localparam logic [VW-1:0] VS_LAST   = VW'(VSYNC_LINES - 1);
  localparam logic [VW-1:0] VB_LAST   = VW'(V_BACK - 1);
  localparam logic [VW-1:0] VA_LAST   = VW'(V_ACTIVE - 1);
  localparam logic [VW-1:0] VF_LAST   = VW'(V_FRONT - 1);
  localparam logic [PW-1:0] PIX_LAST  = PW'(BAR_W - 1);

  typedef enum logic [2:0] {IDLE, VSYNC_S, VBACK, ACTIVE, VFRONT} state_e;

  state_e          state_q, state_d;
  logic [HW-1:0]   hcnt_q, hcnt_d;
  logic [VW-1:0]   vcnt_q, vcnt_d;
  logic            ph_q, ph_d;
  logic [PW-1:0]   pix_q, pix_d;
  logic [2:0]      bar_q, bar_d;
  logic            vsync_q, vsync_d;
  logic            href_q, href_d;
  logic            done_q, done_d;
  logic [7:0]      data_q, data_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            lineEnd;
  logic [15:0]     rgb;

  function automatic logic [15:0] barColour(input logic [2:0] b);
    case (b)
      3'd0:    return 16'hFFFF;
      3'd1:    return 16'hFFE0;
      3'd2:    return 16'h07FF;
      3'd3:    return 16'h07E0;
      3'd4:    return 16'hF81F;
      3'd5:    return 16'hF800;
      3'd6:    return 16'h001F;
      default: return 16'h0000;
    endcase
  endfunction

  // Frame sequencing: hcnt sweeps each line period, vcnt counts lines within the current phase.
  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    vcnt_d  = vcnt_q;
    lineEnd = (hcnt_q == H_LAST);
    if (state_q != IDLE) begin
      hcnt_d = lineEnd ? '0 : hcnt_q + HW'(1);
      if (lineEnd) vcnt_d = vcnt_q + VW'(1);
    end
    case (state_q)
      IDLE: begin
        if (ENABLE) begin
          state_d = VSYNC_S;
          hcnt_d  = '0;
          vcnt_d  = '0;
        end
      end
      VSYNC_S: if (lineEnd && vcnt_q == VS_LAST) begin state_d = VBACK;  vcnt_d = '0; end
      VBACK:   if (lineEnd && vcnt_q == VB_LAST) begin state_d = ACTIVE; vcnt_d = '0; end
      ACTIVE:  if (lineEnd && vcnt_q == VA_LAST) begin state_d = VFRONT; vcnt_d = '0; end
      VFRONT: begin
        if (lineEnd && vcnt_q == VF_LAST) begin
          state_d = ENABLE ? VSYNC_S : IDLE;
          vcnt_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next-state counters so the registered pins line up with the state they describe.
  always_comb begin
    ph_d  = ph_q;
    pix_d = pix_q;
    bar_d = bar_q;
    if (hcnt_d == '0) begin
      ph_d  = 1'b0;
      pix_d = '0;
      bar_d = '0;
    end else if (!ph_q) begin
      ph_d = 1'b1;
    end else begin
      ph_d = 1'b0;
      if (pix_q == PIX_LAST) begin
        pix_d = '0;
        bar_d = bar_q + 3'd1;
      end else begin
        pix_d = pix_q + PW'(1);
      end
    end

    rgb     = barColour(bar_d);
    vsync_d = (state_d == VSYNC_S);
    href_d  = (state_d == ACTIVE) && (hcnt_d < H_ACT_END);
    data_d  = href_d ? (ph_d ? rgb[7:0] : rgb[15:8]) : 8'h00;
`ifdef OV_SRC_FRAME_TAG_EN
    if (href_d && vcnt_d == '0 && bar_d == 3'd0 && pix_d == '0) data_d = cnt_q;
`endif
    done_d = (state_d == VFRONT) && (hcnt_d == H_LAST) && (vcnt_d == VF_LAST);
    cnt_d  = done_d ? cnt_q + 8'd1 : cnt_q;
  end

  always_ff @(posedge PCLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= IDLE;
      hcnt_q  <= '0;
      vcnt_q  <= '0;
      ph_q    <= 1'b0;
      pix_q   <= '0;
      bar_q   <= '0;
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
      data_q  <= 8'h00;
      done_q  <= 1'b0;
      cnt_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
      ph_q    <= ph_d;
      pix_q   <= pix_d;
      bar_q   <= bar_d;
      vsync_q <= vsync_d;
      href_q  <= href_d;
      data_q  <= data_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  assign VSYNC      = vsync_q;
  assign HREF       = href_q;
  assign D          = data_q;
  assign FRAME_DONE = done_q;
  assign FRAME_CNT  = cnt_q;

endmodule

// File: tb/tb_ov7670_source_emulator.sv
// Bench for ov7670_source_emulator: instance A runs back-to-back frames then takes a mid-line reset,
// instance B has ENABLE dropped during line 50. Pixel bytes of A are checked through a scoreboard queue.
module tb_ov7670_source_emulator;

  logic       clk = 1'b0;
  logic       rstnA, rstnB, enA, enB;
  logic       vsA, hrA, fdA, vsB, hrB, fdB;
  logic [7:0] dA, fcA, dB, fcB;

  int checks = 0;
  int errors = 0;

  logic [7:0]  expQ[$];
  logic [15:0] bars [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                            16'hF81F, 16'hF800, 16'h001F, 16'h0000};

  int   pulsesA = 0, curLenA = 0, badLenA = 0, overlapA = 0;
  int   pulsesB = 0, overlapB = 0;
  logic prevHrA = 1'b0, prevHrB = 1'b0;

  ov7670_source_emulator dutA (
    .PCLK(clk), .RSTN(rstnA), .ENABLE(enA), .VSYNC(vsA), .HREF(hrA),
    .D(dA), .FRAME_DONE(fdA), .FRAME_CNT(fcA)
  );

  ov7670_source_emulator dutB (
    .PCLK(clk), .RSTN(rstnB), .ENABLE(enB), .VSYNC(vsB), .HREF(hrB),
    .D(dB), .FRAME_DONE(fdB), .FRAME_CNT(fcB)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic rstA, input logic rstB, input logic eA, input logic eB);
    rstnA = rstA;
    rstnB = rstB;
    enA   = eA;
    enB   = eB;
  endtask

  // Expected bytes of one active line: 20 pixels per bar, high byte first.
  task automatic pushLine(input int lineIdx, input int frameIdx);
    logic [15:0] px;
    for (int p = 0; p < 160; p++) begin
      px = bars[p / 20];
`ifdef OV_SRC_FRAME_TAG_EN
      if (lineIdx == 0 && p == 0) px = {frameIdx[7:0], frameIdx[7:0]};
`endif
      expQ.push_back(px[15:8]);
      expQ.push_back(px[7:0]);
    end
  endtask

  // Scoreboard monitor: every HREF-qualified byte of A consumes one expected byte.
  always @(negedge clk) begin
    logic [7:0] expByte;
    if (rstnA && hrA) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpectedByte actual=%0h required=none", dA);
      end else begin
        expByte = expQ.pop_front();
        checkOutput("pixelByte", {24'h0, dA}, {24'h0, expByte});
      end
    end
  end

  always @(negedge clk) begin
    if (hrA && !prevHrA) pulsesA++;
    if (hrA) curLenA++;
    else begin
      if (prevHrA && curLenA != 320) badLenA++;
      curLenA = 0;
    end
    if (vsA && hrA) overlapA++;
    prevHrA = hrA;
    if (hrB && !prevHrB) pulsesB++;
    if (vsB && hrB) overlapB++;
    prevHrB = hrB;
  end

  task automatic runDutA();
    int n, vsLen, backLen, hiLen, loLen, cyc;
    n = 0;
    while (!vsA && n < 10) begin @(negedge clk); n++; end
    checkOutput("vsyncStartLatency", n, 1);
    vsLen = 0;
    while (vsA && vsLen < 5000) begin vsLen++; @(negedge clk); end
    checkOutput("vsyncHighCycles", vsLen, 1008);
    backLen = 0;
    while (!hrA && backLen < 5000) begin backLen++; @(negedge clk); end
    checkOutput("vbackLowCycles", backLen, 3360);
    hiLen = 0;
    while (hrA && hiLen < 1000) begin hiLen++; @(negedge clk); end
    checkOutput("firstHrefHigh", hiLen, 320);
    loLen = 0;
    while (!hrA && loLen < 1000) begin loLen++; @(negedge clk); end
    checkOutput("firstHrefLow", loLen, 16);
    cyc = vsLen + backLen + hiLen + loLen;
    while (!fdA && cyc < 50000) begin cyc++; @(negedge clk); end
    checkOutput("frameDoneSeen", fdA, 1);
    checkOutput("frameLength", cyc + 1, 45360);
    checkOutput("hrefPulsesFrame", pulsesA, 120);
    checkOutput("hrefLengthErrors", badLenA, 0);
    checkOutput("frameCntAfterDone", fcA, 1);
    checkOutput("vsyncDuringDone", vsA, 0);
    checkOutput("scoreboardDrained", expQ.size(), 0);
    @(negedge clk);
    checkOutput("frameDonePulseWidth", fdA, 0);
    checkOutput("backToBackVsync", vsA, 1);
    checkOutput("syncOverlapA", overlapA, 0);

    pushLine(0, 1);
    n = 0;
    while (!hrA && n < 5000) begin n++; @(negedge clk); end
    repeat (100) @(negedge clk);
    checkOutput("hrefBeforeReset", hrA, 1);
    #2;
    rstnA = 1'b0;
    #1;
    checkOutput("resetHref", hrA, 0);
    checkOutput("resetVsync", vsA, 0);
    checkOutput("resetD", dA, 0);
    checkOutput("resetFrameCnt", fcA, 0);
    n = 0;
    repeat (20) begin @(negedge clk); if (fdA) n++; end
    checkOutput("frameDoneDuringReset", n, 0);
    expQ.delete();
  endtask

  task automatic runDutB();
    int n, busy;
    n = 0;
    while (pulsesB < 51 && n < 50000) begin n++; @(negedge clk); end
    enB = 1'b0;
    n = 0;
    while (!fdB && n < 50000) begin n++; @(negedge clk); end
    checkOutput("dropFrameDoneSeen", fdB, 1);
    checkOutput("dropHrefPulses", pulsesB, 120);
    checkOutput("dropFrameCnt", fcB, 1);
    busy = 0;
    repeat (20) begin
      @(negedge clk);
      if (vsB || hrB || fdB || dB != 8'h00) busy++;
    end
    checkOutput("idleAfterDrop", busy, 0);
    checkOutput("idleFrameCnt", fcB, 1);
    checkOutput("syncOverlapB", overlapB, 0);
  endtask

  initial begin
    #900000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    repeat (3) @(negedge clk);
    checkOutput("resetStateVsync", vsA, 0);
    checkOutput("resetStateHref", hrA, 0);
    checkOutput("resetStateD", dA, 0);
    checkOutput("resetStateDone", fdA, 0);
    checkOutput("resetStateCnt", fcA, 0);
    checkOutput("resetStateVsyncB", vsB, 0);
    for (int ln = 0; ln < 120; ln++) pushLine(ln, 0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
    fork
      runDutA();
      runDutB();
    join
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
